// File: rtl/ula_pkg.sv
// Shared constants for the datapath ALU: the 4-bit control codes produced by
// the ALU control unit and the state encoding of the iterative MULT/DIV unit.
package ula_pkg;

    // ALU control codes
    localparam logic [3:0] ULA_AND  = 4'b0000;
    localparam logic [3:0] ULA_OR   = 4'b0001;
    localparam logic [3:0] ULA_ADD  = 4'b0010;
    localparam logic [3:0] ULA_XOR  = 4'b0011;
    localparam logic [3:0] ULA_SUB  = 4'b0110;
    localparam logic [3:0] ULA_SLT  = 4'b0111;
    localparam logic [3:0] ULA_MULT = 4'b1000;
    localparam logic [3:0] ULA_DIV  = 4'b1001;
    localparam logic [3:0] ULA_NOR  = 4'b1100;
    localparam logic [3:0] ULA_SRL  = 4'b1101;
    localparam logic [3:0] ULA_SLL  = 4'b1111;

    // Iterative MULT/DIV state encoding
    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] CALCULA = 2'd1;
    localparam logic [1:0] AJUSTE  = 2'd2;

endpackage

// File: rtl/multdiv_iterativo.sv
// Iterative signed MULT/DIV unit, one bit per cycle. Works on operand
// magnitudes in CALCULA and applies the sign correction in AJUSTE, where
// HI/LO are written and pronto is raised for one cycle.
module multdiv_iterativo
    import ula_pkg::*;
#(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         controle_alu,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    input  logic               inicio,
    output logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] lo,
    output logic               ocupado,
    output logic               pronto
);

    localparam int CONT_W = $clog2(LARGURA) + 1;
    localparam logic [CONT_W-1:0]    CONT_ULTIMO = CONT_W'(LARGURA - 1);
    localparam logic [CONT_W-1:0]    CONT_UM     = {{(CONT_W-1){1'b0}}, 1'b1};
    localparam logic [LARGURA-1:0]   ZERO        = {LARGURA{1'b0}};
    localparam logic [LARGURA-1:0]   UM          = {{(LARGURA-1){1'b0}}, 1'b1};
    localparam logic [LARGURA-1:0]   UNS         = {LARGURA{1'b1}};
    localparam logic [2*LARGURA-1:0] UM_DUPLO    = {{(2*LARGURA-1){1'b0}}, 1'b1};

    logic [1:0]           estado_r;
    logic [CONT_W-1:0]    cont_r;
    logic                 op_div_r;
    logic                 neg_res_r;   // sign of product / quotient
    logic                 neg_rem_r;   // sign of remainder (dividend sign)
    logic                 div_zero_r;
    logic [LARGURA-1:0]   a_orig_r;    // dividend kept for divide-by-zero HI
    logic [LARGURA-1:0]   mag_b_r;
    logic [LARGURA-1:0]   acc_r;       // MULT upper half / DIV partial remainder
    logic [LARGURA-1:0]   mq_r;        // MULT multiplier->lower half / DIV dividend->quotient
    logic [LARGURA-1:0]   hi_r;
    logic [LARGURA-1:0]   lo_r;
    logic                 pronto_r;

    logic                 inicia_s;
    logic [LARGURA-1:0]   mag_a_s;
    logic [LARGURA-1:0]   mag_b_s;
    logic [LARGURA:0]     soma_s;
    logic [LARGURA:0]     rem_desl_s;
    logic [LARGURA:0]     dif_s;
    logic [LARGURA-1:0]   acc_prox_s;
    logic [LARGURA-1:0]   mq_prox_s;
    logic [2*LARGURA-1:0] prod_s;
    logic [LARGURA-1:0]   quoc_s;
    logic [LARGURA-1:0]   resto_s;
    logic [LARGURA-1:0]   hi_fim_s;
    logic [LARGURA-1:0]   lo_fim_s;

    // Start qualification and operand magnitudes captured at the start edge
    always_comb begin
        inicia_s = (estado_r == OCIOSO) && inicio &&
                   ((controle_alu == ULA_MULT) || (controle_alu == ULA_DIV));
        mag_a_s  = a[LARGURA-1] ? (~a + UM) : a;
        mag_b_s  = b[LARGURA-1] ? (~b + UM) : b;
    end

    // One iteration: shift-add for MULT, restoring shift-subtract for DIV
    always_comb begin
        soma_s     = {1'b0, acc_r} + {1'b0, (mq_r[0] ? mag_b_r : ZERO)};
        rem_desl_s = {acc_r, mq_r[LARGURA-1]};
        dif_s      = rem_desl_s - {1'b0, mag_b_r};
        if (op_div_r) begin
            if (!dif_s[LARGURA]) begin
                acc_prox_s = dif_s[LARGURA-1:0];
                mq_prox_s  = {mq_r[LARGURA-2:0], 1'b1};
            end else begin
                acc_prox_s = rem_desl_s[LARGURA-1:0];
                mq_prox_s  = {mq_r[LARGURA-2:0], 1'b0};
            end
        end else begin
            acc_prox_s = soma_s[LARGURA:1];
            mq_prox_s  = {soma_s[0], mq_r[LARGURA-1:1]};
        end
    end

    // Sign correction and HI/LO selection applied in AJUSTE
    always_comb begin
        prod_s  = neg_res_r ? (~{acc_r, mq_r} + UM_DUPLO) : {acc_r, mq_r};
        quoc_s  = neg_res_r ? (~mq_r + UM) : mq_r;
        resto_s = neg_rem_r ? (~acc_r + UM) : acc_r;
        if (op_div_r) begin
            if (div_zero_r) begin
                hi_fim_s = a_orig_r;
                lo_fim_s = UNS;
            end else begin
                hi_fim_s = resto_s;
                lo_fim_s = quoc_s;
            end
        end else begin
            hi_fim_s = prod_s[2*LARGURA-1:LARGURA];
            lo_fim_s = prod_s[LARGURA-1:0];
        end
    end

    // FSM, iteration counter, working registers and HI/LO
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r   <= OCIOSO;
            cont_r     <= {CONT_W{1'b0}};
            op_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            a_orig_r   <= ZERO;
            mag_b_r    <= ZERO;
            acc_r      <= ZERO;
            mq_r       <= ZERO;
            hi_r       <= ZERO;
            lo_r       <= ZERO;
            pronto_r   <= 1'b0;
        end else begin
            pronto_r <= 1'b0;
            case (estado_r)
                OCIOSO: begin
                    if (inicia_s) begin
                        op_div_r   <= (controle_alu == ULA_DIV);
                        neg_res_r  <= a[LARGURA-1] ^ b[LARGURA-1];
                        neg_rem_r  <= a[LARGURA-1];
                        div_zero_r <= (b == ZERO);
                        a_orig_r   <= a;
                        mag_b_r    <= mag_b_s;
                        acc_r      <= ZERO;
                        mq_r       <= mag_a_s;
                        cont_r     <= {CONT_W{1'b0}};
                        estado_r   <= CALCULA;
                    end
                end
                CALCULA: begin
                    acc_r <= acc_prox_s;
                    mq_r  <= mq_prox_s;
                    if (cont_r == CONT_ULTIMO) begin
                        cont_r   <= {CONT_W{1'b0}};
                        estado_r <= AJUSTE;
                    end else begin
                        cont_r <= cont_r + CONT_UM;
                    end
                end
                AJUSTE: begin
                    hi_r     <= hi_fim_s;
                    lo_r     <= lo_fim_s;
                    pronto_r <= 1'b1;
                    estado_r <= OCIOSO;
                end
                default: begin
                    estado_r <= OCIOSO;
                    cont_r   <= {CONT_W{1'b0}};
                end
            endcase
        end
    end

    assign hi      = hi_r;
    assign lo      = lo_r;
    assign pronto  = pronto_r;
    assign ocupado = (estado_r != OCIOSO);

endmodule

// File: rtl/ula_multiciclo.sv
// Datapath ALU: combinational single-cycle operations plus an iterative
// signed MULT/DIV unit that writes HI/LO with a busy/done handshake.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         controle_alu,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    input  logic [4:0]         shamt,
    input  logic               inicio,
    output logic [LARGURA-1:0] resultado,
    output logic               zero,
    output logic               overflow,
    output logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] lo,
    output logic               ocupado,
    output logic               pronto
);

    localparam int MSB = LARGURA - 1;
    localparam logic [LARGURA-1:0] ZERO = {LARGURA{1'b0}};
    localparam logic [LARGURA-1:0] UM   = {{(LARGURA-1){1'b0}}, 1'b1};

    logic [LARGURA-1:0] soma_s;
    logic [LARGURA-1:0] dif_s;
    logic [LARGURA-1:0] resultado_s;
    logic               overflow_s;

    // Single-cycle operations; MULT, DIV and unknown codes give 0
    always_comb begin
        soma_s      = a + b;
        dif_s       = a - b;
        resultado_s = ZERO;
        overflow_s  = 1'b0;
        case (controle_alu)
            ULA_ADD: begin
                resultado_s = soma_s;
                overflow_s  = (a[MSB] == b[MSB]) && (soma_s[MSB] != a[MSB]);
            end
            ULA_SUB: begin
                resultado_s = dif_s;
                overflow_s  = (a[MSB] != b[MSB]) && (dif_s[MSB] != a[MSB]);
            end
            ULA_AND: resultado_s = a & b;
            ULA_OR:  resultado_s = a | b;
            ULA_XOR: resultado_s = a ^ b;
            ULA_NOR: resultado_s = ~(a | b);
            ULA_SLT: resultado_s = ($signed(a) < $signed(b)) ? UM : ZERO;
            ULA_SLL: resultado_s = b << shamt;
            ULA_SRL: resultado_s = b >> shamt;
            default: begin
                resultado_s = ZERO;
                overflow_s  = 1'b0;
            end
        endcase
    end

    assign resultado = resultado_s;
    assign overflow  = overflow_s;
    assign zero      = (resultado_s == ZERO);

    multdiv_iterativo #(
        .LARGURA (LARGURA)
    ) u_multdiv (
        .clock        (clock),
        .reset        (reset),
        .controle_alu (controle_alu),
        .a            (a),
        .b            (b),
        .inicio       (inicio),
        .hi           (hi),
        .lo           (lo),
        .ocupado      (ocupado),
        .pronto       (pronto)
    );

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_ula_multiciclo;
    import ula_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  controle_alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        inicio;
    logic [31:0] resultado;
    logic        zero;
    logic        overflow;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ocupado;
    logic        pronto;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ov;
    } comb_esp_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_esp_t;

    comb_esp_t fila_comb[$];
    md_esp_t   fila_md[$];

    int  testes = 0;
    int  falhas = 0;
    int  ciclos_ocup = 0;
    logic comb_valido = 1'b0;
    logic verif_pulso = 1'b0;

    ula_multiciclo #(.LARGURA(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .controle_alu (controle_alu),
        .a            (a),
        .b            (b),
        .shamt        (shamt),
        .inicio       (inicio),
        .resultado    (resultado),
        .zero         (zero),
        .overflow     (overflow),
        .hi           (hi),
        .lo           (lo),
        .ocupado      (ocupado),
        .pronto       (pronto)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        testes++;
        if (atual !== esperado) begin
            falhas++;
            $display("FAIL %s: got %h expected %h", nome, atual, esperado);
        end
    endtask

    // Monitor: compares combinational results and HI/LO against the scoreboard
    always @(negedge clock) begin
        comb_esp_t ec;
        md_esp_t   em;
        if (comb_valido) begin
            if (fila_comb.size() == 0) begin
                testes++; falhas++;
                $display("FAIL comb_fila: result presented with no expectation queued");
            end else begin
                ec = fila_comb.pop_front();
                verifica("resultado", resultado, ec.res);
                verifica("zero", {31'd0, zero}, {31'd0, ec.z});
                verifica("overflow", {31'd0, overflow}, {31'd0, ec.ov});
            end
        end
        if (verif_pulso) begin
            verifica("pronto_pulso", {31'd0, pronto}, 32'd0);
            verif_pulso = 1'b0;
        end
        if (pronto) begin
            verif_pulso = 1'b1;
            if (fila_md.size() == 0) begin
                testes++; falhas++;
                $display("FAIL pronto_inesperado: pronto=1 with no operation expected");
            end else begin
                em = fila_md.pop_front();
                verifica("hi", hi, em.hi);
                verifica("lo", lo, em.lo);
                verifica("latencia_ocupado", 32'(ciclos_ocup), 32'd33);
            end
        end
        if (ocupado) ciclos_ocup++;
        else         ciclos_ocup = 0;
    end

    task automatic testa_comb(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                              input logic [4:0] sh, input logic [31:0] res, input logic z, input logic ov);
        comb_esp_t e;
        e.res = res; e.z = z; e.ov = ov;
        @(posedge clock); #1;
        fila_comb.push_back(e);
        controle_alu = op; a = va; b = vb; shamt = sh; comb_valido = 1'b1;
        @(posedge clock); #1;
        comb_valido = 1'b0;
    endtask

    // Issues a start pulse; leaves control just after the accepting edge,
    // with operands scrambled to show they are not re-sampled.
    task automatic iniciar(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        @(posedge clock); #1;
        controle_alu = op; a = va; b = vb; inicio = 1'b1;
        @(posedge clock); #1;
        inicio = 1'b0; a = 32'hA5A5_5A5A; b = 32'h0000_0003; controle_alu = ULA_ADD;
    endtask

    task automatic espera_pronto(input string nome);
        bit visto = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (pronto) begin visto = 1'b1; break; end
        end
        testes++;
        if (!visto) begin
            falhas++;
            $display("FAIL %s: pronto not seen within 100 cycles (got 0 expected 1)", nome);
        end
    endtask

    task automatic espera_md(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                             input logic [31:0] ehi, input logic [31:0] elo, input string nome);
        md_esp_t e;
        e.hi = ehi; e.lo = elo;
        fila_md.push_back(e);
        iniciar(op, va, vb);
        espera_pronto(nome);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got timeout expected finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        md_esp_t e;
        reset = 1'b1; inicio = 1'b0; controle_alu = ULA_AND;
        a = 32'd0; b = 32'd0; shamt = 5'd0;
        repeat (2) @(posedge clock);
        #1;
        verifica("reset_hi", hi, 32'd0);
        verifica("reset_lo", lo, 32'd0);
        verifica("reset_ocupado", {31'd0, ocupado}, 32'd0);
        verifica("reset_pronto", {31'd0, pronto}, 32'd0);
        reset = 1'b0;

        // Combinational operations
        testa_comb(ULA_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b1);
        testa_comb(ULA_SUB, 32'h1234_5678, 32'h1234_5678, 5'd0,  32'h0000_0000, 1'b1, 1'b0);
        testa_comb(ULA_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0);
        testa_comb(ULA_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1, 1'b0);
        testa_comb(ULA_SLL, 32'h1234_5678, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
        testa_comb(ULA_SRL, 32'h1234_5678, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0);
        testa_comb(ULA_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0, 1'b0, 1'b0);
        testa_comb(ULA_OR,  32'h0F00_0000, 32'h0000_00F0, 5'd0,  32'h0F00_00F0, 1'b0, 1'b0);
        testa_comb(ULA_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  32'hF0F0_0F0F, 1'b0, 1'b0);
        testa_comb(ULA_NOR, 32'h0000_0000, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0);
        testa_comb(ULA_SUB, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1);
        testa_comb(ULA_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0);
        testa_comb(ULA_MULT, 32'h0000_0005, 32'h0000_0007, 5'd0, 32'h0000_0000, 1'b1, 1'b0);
        testa_comb(4'b0101, 32'h0000_0005, 32'h0000_0007, 5'd0,  32'h0000_0000, 1'b1, 1'b0);

        // inicio with a non-MULT/DIV code is ignored
        @(posedge clock); #1;
        controle_alu = ULA_ADD; inicio = 1'b1;
        @(posedge clock); #1;
        inicio = 1'b0;
        verifica("inicio_ignorado_ocupado", {31'd0, ocupado}, 32'd0);

        // MULT / DIV
        espera_md(ULA_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
        espera_md(ULA_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        espera_md(ULA_DIV,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, "div_zero");
        espera_md(ULA_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min");
        espera_md(ULA_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_divisor_neg");
        espera_md(ULA_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min");
        espera_md(ULA_MULT, 32'h1234_5678, 32'h0000_0002, 32'h0000_0000, 32'h2468_ACF0, "mult_pos");

        // Start mid-operation is ignored; a start on the pronto cycle is accepted
        e.hi = 32'h0000_0001; e.lo = 32'h0000_0000;
        fila_md.push_back(e);
        iniciar(ULA_MULT, 32'h0001_0000, 32'h0001_0000);
        repeat (10) @(posedge clock);
        #1;
        controle_alu = ULA_DIV; a = 32'h0000_0063; b = 32'h0000_0003; inicio = 1'b1;
        @(posedge clock); #1;
        inicio = 1'b0;
        espera_pronto("mult_meio");
        e.hi = 32'h0000_0000; e.lo = 32'h0000_0001;
        fila_md.push_back(e);
        controle_alu = ULA_MULT; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; inicio = 1'b1;
        @(posedge clock); #1;
        inicio = 1'b0; a = 32'h0; b = 32'h0;
        #1;
        verifica("costas_ocupado", {31'd0, ocupado}, 32'd1);
        espera_pronto("mult_costas");

        // Reset aborts a MULT at iteration 15
        iniciar(ULA_MULT, 32'h0000_0003, 32'h0000_0005);
        repeat (15) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        verifica("abort_ocupado", {31'd0, ocupado}, 32'd0);
        verifica("abort_pronto", {31'd0, pronto}, 32'd0);
        verifica("abort_hi", hi, 32'd0);
        verifica("abort_lo", lo, 32'd0);
        repeat (40) @(posedge clock);
        #1;
        verifica("abort_hi_depois", hi, 32'd0);

        // Reset wins over inicio in the same cycle
        controle_alu = ULA_MULT; a = 32'd9; b = 32'd9; inicio = 1'b1; reset = 1'b1;
        @(posedge clock); #1;
        inicio = 1'b0; reset = 1'b0;
        verifica("reset_prioridade", {31'd0, ocupado}, 32'd0);

        espera_md(ULA_MULT, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, "mult_pos_reset");

        repeat (3) @(posedge clock);
        #1;
        verifica("fila_md_vazia", 32'(fila_md.size()), 32'd0);
        verifica("fila_comb_vazia", 32'(fila_comb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- Datapath ALU that consumes the 4-bit control code from the ALU control unit.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL) are combinational and drive the main result and flags.
- MULT and DIV run on an iterative, 1-bit-per-cycle signed unit that writes the HI/LO registers.
- Busy/done handshake lets the main control unit stall the processor while MULT/DIV is running.

Parameters:
- LARGURA, 32, datapath width in bits; iteration count equals LARGURA.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- controle_alu  in  4  operation code: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 XOR, 1100 NOR, 0111 SLT, 1111 SLL, 1101 SRL, 1000 MULT, 1001 DIV.
- a  in  LARGURA  operand rs.
- b  in  LARGURA  operand rt; this is the shifted operand for SLL/SRL.
- shamt  in  5  shift amount.
- inicio  in  1  start pulse for MULT/DIV.
- resultado  out  LARGURA  combinational result.
- zero  out  1  high when resultado == 0.
- overflow  out  1  signed overflow on ADD/SUB; 0 for all other codes.
- hi  out  LARGURA  HI register: MULT upper half, DIV remainder.
- lo  out  LARGURA  LO register: MULT lower half, DIV quotient.
- ocupado  out  1  MULT/DIV in progress.
- pronto  out  1  one-cycle pulse after HI/LO are written.

Behaviour:
- Combinational path:
  - resultado is a pure function of controle_alu, a, b and shamt; it is not affected by reset.
  - SLT is a signed compare, giving 0 or 1.
  - SLL is b << shamt; SRL is a logical b >> shamt.
  - ADD/SUB wrap modulo 2^LARGURA.
  - overflow = operand signs are equal (after negating b for SUB) and the result sign differs.
  - MULT, DIV and undefined codes drive resultado = 0 and overflow = 0.
- FSM states:
  - OCIOSO: idle.
  - CALCULA: LARGURA iterations of shift-add (MULT) or restoring shift-subtract (DIV), run on operand magnitudes.
  - AJUSTE: sign correction, then HI/LO written.
- Start: inicio sampled high in OCIOSO with code 1000 or 1001 at edge E0 → latch |a|, |b|, sign info and op type; go to CALCULA with counter = 0.
- Ignored starts:
  - inicio while ocupado = 1.
  - inicio with any other code.
- Timing:
  - Edges E1..E32 (LARGURA edges) perform the iterations; at E32 the FSM moves to AJUSTE.
  - At E33, hi/lo are written and the FSM returns to OCIOSO.
  - pronto is high for exactly the cycle E33→E34.
- ocupado = (state != OCIOSO), i.e. high for LARGURA+1 cycles. It is decoded from state, not registered separately.
- A new start is accepted at E34, the edge where pronto is high (back-to-back operation).
- MULT: signed 64-bit product; {hi, lo} = a*b.
- DIV signed rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - MIN_INT / -1 gives lo = 80000000, hi = 0.
- DIV by zero: same latency; lo = FFFFFFFF, hi = a unchanged.
- hi/lo hold their value between operations. They are updated only at AJUSTE and read directly; there is no bypass during CALCULA.
- Operand inputs may change after E0 without affecting the operation in progress.
- Reset: any cycle where reset is high →
  - state OCIOSO, counter 0;
  - hi = lo = 0, pronto = 0, ocupado = 0;
  - an in-progress operation is aborted with no HI/LO write.
  - reset has priority over inicio in the same cycle.

Decomposition:
- Shared package ula_pkg holds:
  - the 4-bit control code constants (ULA_ADD, ULA_SUB, ULA_AND, ULA_OR, ULA_XOR, ULA_NOR, ULA_SLT, ULA_SLL, ULA_SRL, ULA_MULT, ULA_DIV), also used by the ALU control unit;
  - the FSM state encoding.
- One sub-module, multdiv_iterativo, owns the FSM, counter, HI/LO, ocupado and pronto.
- The top level holds the combinational ALU and instantiates multdiv_iterativo.

Test Plan:
- ADD a=7FFFFFFF, b=00000001 → resultado=80000000, overflow=1, zero=0. SUB a=b=12345678 → resultado=0, zero=1, overflow=0.
- SLT a=FFFFFFFF, b=00000001 → resultado=1. SLL b=00000001, shamt=31 → 80000000. SRL b=80000000, shamt=31 → 00000001.
- MULT a=FFFFFFFD (-3), b=00000007, inicio pulse:
  - ocupado high for 33 cycles; pronto pulses once;
  - hi=FFFFFFFF, lo=FFFFFFEB.
- DIV a=FFFFFFF9 (-7), b=00000002 → lo=FFFFFFFD, hi=FFFFFFFF. DIV a=5, b=0 → lo=FFFFFFFF, hi=00000005 with the same latency.
- Second inicio at mid-operation cycle 10 with different operands → ignored, first result intact. A new MULT started on the pronto cycle → accepted, result correct.
- Reset asserted at iteration 15 of a MULT → next cycle ocupado=0, pronto=0, hi=lo=0, no pronto afterward; a subsequent MULT completes correctly.
